// File: rtl/dsp48a1_slice.sv
// DSP48A1-style multiply-accumulate slice: D+/-B pre-adder, 18x18 unsigned
// multiplier, 48-bit post-adder/subtracter with X/Z muxes and carry logic.
// Every stage has an optional register with its own CE and active-low sync reset.

// Optional pipeline stage: register with reset-over-CE priority, or a plain wire.
module dsp48a1_pipe_reg #(
  parameter int W   = 18,
  parameter int USE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  generate
    if (USE != 0) begin : g_reg
      // Stage register: reset clears, CE loads, otherwise hold.
      always_ff @(posedge clk) begin
        if (!rst_n)  dout <= '0;
        else if (ce) dout <= din;
      end
    end else begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, ce};
      assign dout      = din;
    end
  endgenerate
endmodule

module dsp48a1_slice #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        clk,
  input  logic        rsta,
  input  logic        rstb,
  input  logic        rstc,
  input  logic        rstcarryin,
  input  logic        rstd,
  input  logic        rstm,
  input  logic        rstopmode,
  input  logic        rstp,
  input  logic [17:0] a,
  input  logic [17:0] b,
  input  logic [17:0] d,
  input  logic [47:0] c,
  input  logic        carryin,
  input  logic [7:0]  opmode,
  input  logic [47:0] pcin,
  input  logic [17:0] bcin,
  input  logic        cea,
  input  logic        ceb,
  input  logic        cec,
  input  logic        cecarryin,
  input  logic        ced,
  input  logic        cem,
  input  logic        ceopmode,
  input  logic        cep,
  output logic [35:0] m,
  output logic [47:0] p,
  output logic        carryout,
  output logic        carryoutf,
  output logic [17:0] bcout,
  output logic [47:0] pcout
);

  logic [17:0] a0, a1, b_src, b0, b1, d_r, pre;
  logic [47:0] c_r, x, z, p_r;
  logic [35:0] mult, m_r;
  logic [7:0]  op;
  logic        cin_src, cyi, cyo;
  logic [48:0] post;

  // Ports that only some parameter choices consume.
  logic unused_ok;
  assign unused_ok = ^{bcin, carryin};

  assign b_src   = (B_INPUT == "DIRECT")  ? b :
                   (B_INPUT == "CASCADE") ? bcin : 18'd0;

  // Carry source is taken after the OPMODE register so it tracks the opcode.
  assign cin_src = (CARRYINSEL == "OPMODE5") ? op[5] :
                   (CARRYINSEL == "CARRYIN") ? carryin : 1'b0;

  dsp48a1_pipe_reg #(.W(18), .USE(A0REG)) u_a0 (.clk, .rst_n(rsta), .ce(cea), .din(a),     .dout(a0));
  dsp48a1_pipe_reg #(.W(18), .USE(A1REG)) u_a1 (.clk, .rst_n(rsta), .ce(cea), .din(a0),    .dout(a1));
  dsp48a1_pipe_reg #(.W(18), .USE(B0REG)) u_b0 (.clk, .rst_n(rstb), .ce(ceb), .din(b_src), .dout(b0));
  dsp48a1_pipe_reg #(.W(18), .USE(B1REG)) u_b1 (.clk, .rst_n(rstb), .ce(ceb), .din(pre),   .dout(b1));
  dsp48a1_pipe_reg #(.W(48), .USE(CREG))  u_c  (.clk, .rst_n(rstc), .ce(cec), .din(c),     .dout(c_r));
  dsp48a1_pipe_reg #(.W(18), .USE(DREG))  u_d  (.clk, .rst_n(rstd), .ce(ced), .din(d),     .dout(d_r));
  dsp48a1_pipe_reg #(.W(36), .USE(MREG))  u_m  (.clk, .rst_n(rstm), .ce(cem), .din(mult),  .dout(m_r));
  dsp48a1_pipe_reg #(.W(8),  .USE(OPMODEREG))   u_op  (.clk, .rst_n(rstopmode),  .ce(ceopmode),  .din(opmode),    .dout(op));
  dsp48a1_pipe_reg #(.W(1),  .USE(CARRYINREG))  u_cyi (.clk, .rst_n(rstcarryin), .ce(cecarryin), .din(cin_src),   .dout(cyi));
  dsp48a1_pipe_reg #(.W(48), .USE(PREG))        u_p   (.clk, .rst_n(rstp),       .ce(cep),       .din(post[47:0]), .dout(p_r));
  dsp48a1_pipe_reg #(.W(1),  .USE(CARRYOUTREG)) u_cyo (.clk, .rst_n(rstp),       .ce(cep),       .din(post[48]),   .dout(cyo));

  // Pre-adder: pass B0 through, or D plus/minus B0 with 18-bit wrap.
  always_comb begin
    pre = b0;
    if (op[4]) pre = op[6] ? (d_r - b0) : (d_r + b0);
  end

  assign mult = 36'(a1) * 36'(b1);

  // X/Z operand selection for the post-adder.
  always_comb begin
    x = '0;
    z = '0;
    unique case (op[1:0])
      2'd0: x = '0;
      2'd1: x = {12'd0, m_r};
      2'd2: x = p_r;
      2'd3: x = {d_r[11:0], a1, b1};
    endcase
    unique case (op[3:2])
      2'd0: z = '0;
      2'd1: z = pcin;
      2'd2: z = p_r;
      2'd3: z = c_r;
    endcase
  end

  // Post-adder: bit 48 is the carry (add) or borrow (subtract).
  always_comb begin
    if (op[7]) post = {1'b0, z} - ({1'b0, x} + 49'(cyi));
    else       post = {1'b0, z} + {1'b0, x} + 49'(cyi);
  end

  assign m         = m_r;
  assign p         = p_r;
  assign pcout     = p_r;
  assign carryout  = cyo;
  assign carryoutf = cyo;
  assign bcout     = b1;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Self-checking bench for dsp48a1_slice with default parameters: directed
// steps followed by random held-input vectors checked against a steady-state model.
module tb_dsp48a1_slice;

  logic        clk = 1'b0;
  logic        rsta, rstb, rstc, rstcarryin, rstd, rstm, rstopmode, rstp;
  logic [17:0] a, b, d, bcin;
  logic [47:0] c, pcin;
  logic        carryin;
  logic [7:0]  opmode;
  logic        cea, ceb, cec, cecarryin, ced, cem, ceopmode, cep;
  logic [35:0] m;
  logic [47:0] p, pcout;
  logic        carryout, carryoutf;
  logic [17:0] bcout;

  int checks   = 0;
  int failures = 0;

  dsp48a1_slice dut (
    .clk(clk), .rsta(rsta), .rstb(rstb), .rstc(rstc), .rstcarryin(rstcarryin),
    .rstd(rstd), .rstm(rstm), .rstopmode(rstopmode), .rstp(rstp),
    .a(a), .b(b), .d(d), .c(c), .carryin(carryin), .opmode(opmode),
    .pcin(pcin), .bcin(bcin),
    .cea(cea), .ceb(ceb), .cec(cec), .cecarryin(cecarryin), .ced(ced),
    .cem(cem), .ceopmode(ceopmode), .cep(cep),
    .m(m), .p(p), .carryout(carryout), .carryoutf(carryoutf),
    .bcout(bcout), .pcout(pcout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ce(input logic v);
    {cea, ceb, cec, cecarryin, ced, cem, ceopmode, cep} = {8{v}};
  endtask

  task automatic set_rst(input logic v);
    {rsta, rstb, rstc, rstcarryin, rstd, rstm, rstopmode, rstp} = {8{v}};
  endtask

  task automatic rand_data();
    a = 18'($urandom); b = 18'($urandom); d = 18'($urandom); bcin = 18'($urandom);
    c = {16'($urandom), 32'($urandom)}; pcin = {16'($urandom), 32'($urandom)};
    carryin = 1'($urandom); opmode = 8'($urandom);
  endtask

  task automatic chk_all(input string tag, input logic [17:0] e_bc, input logic [35:0] e_m,
                         input logic [47:0] e_p, input logic e_co);
    chk({tag, ".bcout"},     48'(bcout),     48'(e_bc));
    chk({tag, ".m"},         48'(m),         48'(e_m));
    chk({tag, ".p"},         p,              e_p);
    chk({tag, ".pcout"},     pcout,          e_p);
    chk({tag, ".carryout"},  48'(carryout),  48'(e_co));
    chk({tag, ".carryoutf"}, 48'(carryoutf), 48'(e_co));
  endtask

  // Steady-state result for inputs held constant, P not used as an operand.
  function automatic logic [48:0] model(input logic [17:0] ma, mb, md, input logic [47:0] mc,
                                        input logic [47:0] mpcin, input logic [7:0] mop,
                                        output logic [17:0] bc, output logic [35:0] mm);
    logic [47:0] xv, zv;
    longint unsigned zz, xx, r;
    if (!mop[4])     bc = mb;
    else if (mop[6]) bc = md - mb;
    else             bc = md + mb;
    mm = 36'(ma) * 36'(bc);
    case (mop[1:0])
      2'd1:    xv = 48'(mm);
      2'd3:    xv = {md[11:0], ma, bc};
      default: xv = 48'd0;
    endcase
    case (mop[3:2])
      2'd1:    zv = mpcin;
      2'd3:    zv = mc;
      default: zv = 48'd0;
    endcase
    zz = 64'(zv);
    xx = 64'(xv) + 64'(mop[5]);
    r  = mop[7] ? (zz - xx) : (zz + xx);
    return r[48:0];
  endfunction

  initial begin
    logic [17:0] e_bc;
    logic [35:0] e_m;
    logic [48:0] e_r;

    // Reset: all resets low with random data and enables.
    set_rst(1'b0);
    rand_data();
    {cea, ceb, cec, cecarryin, ced, cem, ceopmode, cep} = 8'($urandom);
    step(1);
    chk_all("reset", 18'd0, 36'd0, 48'd0, 1'b0);

    // C - M with D-B pre-subtract.
    set_rst(1'b1); set_ce(1'b1);
    opmode = 8'b11011101; a = 18'd20; b = 18'd10; c = 48'd350; d = 18'd25;
    pcin = 48'd0; carryin = 1'b0; bcin = 18'd0;
    step(4);
    chk_all("dsub", 18'h0F, 36'h12C, 48'h32, 1'b0);

    opmode = 8'b00010000;
    step(3);
    chk_all("dadd", 18'h23, 36'h2BC, 48'h0, 1'b0);

    opmode = 8'b00001010;
    step(3);
    chk_all("pplusp", 18'h0A, 36'hC8, 48'h0, 1'b0);

    // PCIN - (concat + 1) borrows.
    opmode = 8'b10100111; a = 18'd5; b = 18'd6; c = 48'd350; d = 18'd25; pcin = 48'd3000;
    step(3);
    chk_all("borrow", 18'd6, 36'h1E, 48'hFE6FFFEC0BB1, 1'b1);

    // All enables low: outputs frozen while inputs wander.
    set_ce(1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(1);
    end
    chk_all("hold", 18'd6, 36'h1E, 48'hFE6FFFEC0BB1, 1'b1);

    // rstp beats a low CE; M and B1 keep their values.
    rstp = 1'b0;
    step(1);
    chk_all("rstp", 18'd6, 36'h1E, 48'h0, 1'b0);
    rstp = 1'b1;

    // Accumulate P += M + 1 starting from a cleared P.
    set_ce(1'b1); rstp = 1'b0;
    a = 18'd3; b = 18'd7; d = 18'd0; c = 48'd0; pcin = 48'd0; opmode = 8'b00101001;
    step(4);
    rstp = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("acc.p", p, 48'(22 * k));
    end

    // rstm pulse: M clears for one edge, so P only gains the carry on the edge after.
    rstm = 1'b0;
    step(1);
    chk("rstm.m", 48'(m), 48'd0);
    chk("rstm.p", p, 48'd88);
    rstm = 1'b1;
    step(1);
    chk("rstm.m2", 48'(m), 48'd21);
    chk("rstm.p2", p, 48'd89);
    step(1);
    chk("rstm.p3", p, 48'd111);

    // Random held vectors, P never selected as an operand.
    for (int v = 0; v < 16; v++) begin
      rand_data();
      if (opmode[1:0] == 2'd2) opmode[1:0] = 2'd1;
      if (opmode[3:2] == 2'd2) opmode[3:2] = 2'd3;
      e_r = model(a, b, d, c, pcin, opmode, e_bc, e_m);
      step(5);
      chk_all($sformatf("rnd%0d", v), e_bc, e_m, e_r[47:0], e_r[48]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
